// File: rtl/tlb_search_arbiter_pkg.sv
// tlb_search_arbiter_pkg: requester encoding and TLBP result layout shared by the TLB search arbiter.
package tlb_search_arbiter_pkg;
    localparam int REQ_INST = 0;
    localparam int REQ_DATA = 1;
    localparam int REQ_TLBP = 2;
    localparam int REQ_NUM  = 3;

    // tlbp_result is {~found, index}: the not-found flag sits just above the index bits
    function automatic int tlbp_found_bit(input int tlbnum_width);
        return tlbnum_width;
    endfunction
endpackage

// File: rtl/tlb_search_arbiter_pick.sv
// tlb_arb_pick: one-hot picker, tlbp > forced inst > data > inst, nothing while blocked.
module tlb_arb_pick
    import tlb_search_arbiter_pkg::*;
(
    input  logic [REQ_NUM-1:0] req,
    input  logic               starve_hit,
    input  logic               blocked,
    output logic [REQ_NUM-1:0] gnt
);
    always_comb begin
        gnt = '0;
        if (!blocked) begin
            if (req[REQ_TLBP])
                gnt[REQ_TLBP] = 1'b1;
            else if (starve_hit && req[REQ_INST])
                gnt[REQ_INST] = 1'b1;
            else if (req[REQ_DATA])
                gnt[REQ_DATA] = 1'b1;
            else if (req[REQ_INST])
                gnt[REQ_INST] = 1'b1;
        end
    end
endmodule

// File: rtl/tlb_search_arbiter.sv
// tlb_search_arbiter: shares the TLB search port between fetch, data and TLBP;
// one grant per cycle, result registered and returned one cycle later.
module tlb_search_arbiter
    import tlb_search_arbiter_pkg::*;
#(
    parameter int TLBNUM       = 16,
    parameter int TLBNUM_WIDTH = $clog2(TLBNUM),
    parameter int STARVE_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              entry_hi_asid,
    input  logic [18:0]             entry_hi_vpn2,
    input  logic                    inst_req,
    input  logic [31:0]             inst_vaddr,
    output logic                    inst_gnt,
    input  logic                    data_req,
    input  logic [31:0]             data_vaddr,
    output logic                    data_gnt,
    input  logic                    tlbp_req,
    output logic                    tlbp_gnt,
    input  logic                    tlbw_busy,
    input  logic                    flush,
    output logic [18:0]             s_vpn2,
    output logic                    s_odd_page,
    output logic [7:0]              s_asid,
    input  logic                    s_found,
    input  logic [TLBNUM_WIDTH-1:0] s_index,
    input  logic [19:0]             s_pfn,
    input  logic [2:0]              s_c,
    input  logic                    s_d,
    input  logic                    s_v,
    output logic                    inst_resp_valid,
    output logic                    data_resp_valid,
    output logic                    resp_found,
    output logic [19:0]             resp_pfn,
    output logic [2:0]              resp_c,
    output logic                    resp_d,
    output logic                    resp_v,
    output logic                    tlbp,
    output logic [TLBNUM_WIDTH:0]   tlbp_result
);
    localparam int STARVE_W  = $clog2(STARVE_LIMIT + 1);
    localparam int FOUND_BIT = tlbp_found_bit(TLBNUM_WIDTH);

    logic                blk, inst_q, data_q, starve_hit;
    logic [STARVE_W-1:0] starve;
    logic [REQ_NUM-1:0]  req, gnt;
    logic                unused_ok;

    assign unused_ok = &{1'b0, inst_vaddr[11:0], data_vaddr[11:0]};

    always_comb begin
        req = '0;
        req[REQ_INST] = inst_req;
        req[REQ_DATA] = data_req;
        req[REQ_TLBP] = tlbp_req;
    end

    assign starve_hit = starve == STARVE_W'(STARVE_LIMIT);

    // reset also blocks so no grant leaks out while state is being cleared
    tlb_arb_pick u_pick (
        .req       (req),
        .starve_hit(starve_hit),
        .blocked   (tlbw_busy | blk | reset),
        .gnt       (gnt)
    );

    assign inst_gnt   = gnt[REQ_INST];
    assign data_gnt   = gnt[REQ_DATA];
    assign tlbp_gnt   = gnt[REQ_TLBP];
    assign s_asid     = entry_hi_asid;
    assign s_vpn2     = gnt[REQ_TLBP] ? entry_hi_vpn2 : gnt[REQ_DATA] ? data_vaddr[31:13] : inst_vaddr[31:13];
    assign s_odd_page = gnt[REQ_TLBP] ? 1'b0 : gnt[REQ_DATA] ? data_vaddr[12] : inst_vaddr[12];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk         <= 1'b0;
            inst_q      <= 1'b0;
            data_q      <= 1'b0;
            tlbp        <= 1'b0;
            starve      <= '0;
            resp_found  <= 1'b0;
            resp_pfn    <= '0;
            resp_c      <= '0;
            resp_d      <= 1'b0;
            resp_v      <= 1'b0;
            tlbp_result <= '0;
        end else begin
            blk    <= tlbw_busy;
            inst_q <= gnt[REQ_INST] & ~flush;
            data_q <= gnt[REQ_DATA] & ~flush;
            tlbp   <= gnt[REQ_TLBP];
            starve <= (gnt[REQ_INST] || !inst_req) ? '0 :
                      (gnt[REQ_DATA] && !starve_hit) ? starve + 1'b1 : starve;
            if (|gnt) begin
                resp_found <= s_found;
                resp_pfn   <= s_pfn;
                resp_c     <= s_c;
                resp_d     <= s_d;
                resp_v     <= s_v;
            end
            if (gnt[REQ_TLBP]) begin
                tlbp_result[FOUND_BIT]     <= ~s_found;
                tlbp_result[FOUND_BIT-1:0] <= s_index;
            end
        end
    end

    // a flush arriving in the response cycle still kills that response
    assign inst_resp_valid = inst_q & ~flush;
    assign data_resp_valid = data_q & ~flush;
endmodule
